// File: rtl/weight_loader.sv
// Packs narrow host beats little-endian into weight words and writes them to the linear layer's weight port.
// One write per word, one cycle after the completing beat. No stall toward the consumer; s_ready is simply "in PACK".
module weight_loader #(
  parameter int          pIN_WIDTH          = 32,
  parameter int          pWEIGHT_DATA_WIDTH = 64,
  parameter int          pNUM_WORDS         = 160,
  parameter logic [31:0] pWEIGHT_BASE_ADDR  = 32'h0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          s_valid,
  input  logic [pIN_WIDTH-1:0]          s_data,
  input  logic                          s_last,
  output logic                          s_ready,
  output logic                          load_weight,
  output logic [31:0]                   weight_addr,
  output logic [pWEIGHT_DATA_WIDTH-1:0] weight_data,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);

  localparam int BEATS = pWEIGHT_DATA_WIDTH / pIN_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WW    = (pNUM_WORDS > 1) ? $clog2(pNUM_WORDS) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(pNUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, PACK, FLUSH} state_e;

  state_e                        state_q, state_d;
  logic [BW-1:0]                 beat_q, beat_d;
  logic [WW-1:0]                 word_q, word_d;
  logic [pWEIGHT_DATA_WIDTH-1:0] pack_q, pack_d;
  logic [pWEIGHT_DATA_WIDTH-1:0] data_q, data_d;
  logic [31:0]                   addr_q, addr_d;
  logic                          load_q, load_d;
  logic                          done_q, done_d;
  logic                          error_q, error_d;

  logic accept, last_beat, last_word;

  assign accept    = s_valid && (state_q == PACK);
  assign last_beat = (beat_q == BEAT_LAST);
  assign last_word = (word_q == WORD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      word_q  <= '0;
      pack_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      word_q  <= word_d;
      pack_q  <= pack_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      load_q  <= load_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    word_d  = word_q;
    pack_d  = pack_q;
    data_d  = data_q;
    addr_d  = addr_q;
    load_d  = 1'b0;
    done_d  = 1'b0;
    error_d = error_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PACK;
          beat_d  = '0;
          word_d  = '0;
          error_d = 1'b0;
        end
      end
      PACK: begin
        if (accept) begin
          for (int j = 0; j < BEATS; j++) begin
            if (beat_q == BW'(j)) pack_d[j*pIN_WIDTH +: pIN_WIDTH] = s_data;
          end
          // Early s_last: drop the partial word and abort without a done pulse.
          if (s_last && !(last_beat && last_word)) begin
            error_d = 1'b1;
            state_d = IDLE;
            beat_d  = '0;
            word_d  = '0;
          end else if (last_beat) begin
            load_d = 1'b1;
            data_d = pack_d;
            addr_d = pWEIGHT_BASE_ADDR + 32'(word_q);
            beat_d = '0;
            if (last_word) begin
              state_d = FLUSH;
              done_d  = 1'b1;
              word_d  = '0;
              if (!s_last) error_d = 1'b1;
            end else begin
              word_d = word_q + 1'b1;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready = (state_q == PACK);
    busy    = (state_q != IDLE);
  end

  assign load_weight = load_q;
  assign weight_addr = addr_q;
  assign weight_data = data_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule
